// File: rtl/trb_line_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : trb_line_packer_if
//  Brief    : Byte-stream input and cache-line output handshake bundle for
//             trb_line_packer.
//  Revision : 1.0
// ============================================================================
interface trb_line_packer_if #(
    parameter int LINE_BYTES = 64
);
    logic [7:0]              st_data_in;
    logic                    st_valid_in;
    logic                    st_sop_in;
    logic                    st_eop_in;
    logic                    st_ready_out;
    logic [8*LINE_BYTES-1:0] line_data;
    logic                    line_valid;
    logic                    line_ready;
    logic                    line_sof;
    logic                    line_eof;

    // Packer side
    modport slave (
        input  st_data_in, st_valid_in, st_sop_in, st_eop_in, line_ready,
        output st_ready_out, line_data, line_valid, line_sof, line_eof
    );

    // Stream source / line consumer side
    modport master (
        output st_data_in, st_valid_in, st_sop_in, st_eop_in, line_ready,
        input  st_ready_out, line_data, line_valid, line_sof, line_eof
    );
endinterface
`default_nettype wire

// File: rtl/trb_line_packer.sv
`default_nettype none
// ============================================================================
//  Module   : trb_line_packer
//  Brief    : Packs framed turbo output bytes into cache lines with sof/eof
//             tags, skid-aware backpressure and framing error pulses.
//  Revision : 1.0
// ============================================================================
module trb_line_packer #(
    parameter int FRAME_BYTES = 128,
    parameter int LINE_BYTES  = 64,
    parameter int SKID        = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    trb_line_packer_if.slave bus,
    output logic [15:0]      frame_cnt,
    output logic             err_overflow,
    output logic             err_sop,
    output logic             err_len
);
    localparam int c_LW  = 8 * LINE_BYTES;
    localparam int c_ACW = $clog2(LINE_BYTES + 1);
    localparam int c_FCW = $clog2(FRAME_BYTES + 1);

    logic [c_LW-1:0]  r_acc_data, w_acc_data;
    logic [c_ACW-1:0] r_acc_cnt,  w_acc_cnt;
    logic             r_acc_full, w_acc_full;
    logic             r_acc_sof,  w_acc_sof;
    logic             r_acc_eof,  w_acc_eof;
    logic [c_FCW-1:0] r_frm_cnt,  w_frm_cnt;
    logic [c_LW-1:0]  r_out_data, w_out_data;
    logic             r_out_valid, w_out_valid;
    logic             r_out_sof,  w_out_sof;
    logic             r_out_eof,  w_out_eof;
    logic [15:0]      r_frame_cnt, w_frame_cnt;
    logic             r_err_ovf,  w_err_ovf;
    logic             r_err_sop,  w_err_sop;
    logic             r_err_len,  w_err_len;
    logic             r_ready,    w_ready;

    logic             w_out_take;
    logic             w_restart;
    logic             w_first;
    logic [c_ACW-1:0] w_slot;
    logic [c_LW-1:0]  w_line;
    logic [c_FCW-1:0] w_pos;
    logic             w_end;
    logic             w_sof;
    logic             w_close;

    always_comb begin
        w_acc_data  = r_acc_data;
        w_acc_cnt   = r_acc_cnt;
        w_acc_full  = r_acc_full;
        w_acc_sof   = r_acc_sof;
        w_acc_eof   = r_acc_eof;
        w_frm_cnt   = r_frm_cnt;
        w_out_data  = r_out_data;
        w_out_valid = r_out_valid;
        w_out_sof   = r_out_sof;
        w_out_eof   = r_out_eof;
        w_frame_cnt = r_frame_cnt;
        w_err_ovf   = 1'b0;
        w_err_sop   = 1'b0;
        w_err_len   = 1'b0;
        w_restart   = 1'b0;
        w_first     = 1'b0;
        w_slot      = r_acc_cnt;
        w_line      = r_acc_data;
        w_pos       = r_frm_cnt;
        w_end       = 1'b0;
        w_sof       = r_acc_sof;
        w_close     = 1'b0;
        w_out_take  = r_out_valid && bus.line_ready;

        if (w_out_take) begin
            w_out_valid = 1'b0;
            if (r_out_eof) begin
                w_frame_cnt = r_frame_cnt + 16'd1;
            end
            // A line parked in the accumulator moves out on the accept edge
            if (r_acc_full) begin
                w_out_data  = r_acc_data;
                w_out_sof   = r_acc_sof;
                w_out_eof   = r_acc_eof;
                w_out_valid = 1'b1;
                w_acc_data  = '0;
                w_acc_cnt   = '0;
                w_acc_full  = 1'b0;
                w_acc_sof   = 1'b0;
                w_acc_eof   = 1'b0;
            end
        end

        if (bus.st_valid_in) begin
            if (r_acc_full) begin
                w_err_ovf = 1'b1;
            end else begin
                w_restart = bus.st_sop_in && (r_frm_cnt != '0);
                w_first   = bus.st_sop_in || (r_frm_cnt == '0);
                w_err_sop = bus.st_sop_in != (r_frm_cnt == '0);
                w_slot    = w_restart ? '0 : r_acc_cnt;
                w_line    = w_restart ? '0 : r_acc_data;
                for (int k = 0; k < LINE_BYTES; k++) begin
                    if (w_slot == c_ACW'(k)) begin
                        w_line[8*k +: 8] = bus.st_data_in;
                    end
                end
                w_pos     = (w_first ? '0 : r_frm_cnt) + c_FCW'(1);
                w_end     = bus.st_eop_in || (w_pos == c_FCW'(FRAME_BYTES));
                w_err_len = w_end && !(bus.st_eop_in && (w_pos == c_FCW'(FRAME_BYTES)));
                w_sof     = w_first || r_acc_sof;
                w_close   = (w_slot == c_ACW'(LINE_BYTES - 1)) || w_end;
                w_frm_cnt = w_end ? '0 : w_pos;

                if (w_close && (!r_out_valid || w_out_take)) begin
                    w_out_data  = w_line;
                    w_out_sof   = w_sof;
                    w_out_eof   = w_end;
                    w_out_valid = 1'b1;
                    w_acc_data  = '0;
                    w_acc_cnt   = '0;
                    w_acc_sof   = 1'b0;
                    w_acc_eof   = 1'b0;
                end else begin
                    w_acc_data  = w_line;
                    w_acc_cnt   = w_slot + c_ACW'(1);
                    w_acc_full  = w_close;
                    w_acc_sof   = w_sof;
                    w_acc_eof   = w_end;
                end
            end
        end

        // Leave SKID slots for bytes already in flight when ready drops
        w_ready = !w_acc_full &&
                  (!w_out_valid || (w_acc_cnt <= c_ACW'(LINE_BYTES - SKID)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_data  <= '0;
            r_acc_cnt   <= '0;
            r_acc_full  <= 1'b0;
            r_acc_sof   <= 1'b0;
            r_acc_eof   <= 1'b0;
            r_frm_cnt   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_frame_cnt <= '0;
            r_err_ovf   <= 1'b0;
            r_err_sop   <= 1'b0;
            r_err_len   <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_acc_data  <= w_acc_data;
            r_acc_cnt   <= w_acc_cnt;
            r_acc_full  <= w_acc_full;
            r_acc_sof   <= w_acc_sof;
            r_acc_eof   <= w_acc_eof;
            r_frm_cnt   <= w_frm_cnt;
            r_out_data  <= w_out_data;
            r_out_valid <= w_out_valid;
            r_out_sof   <= w_out_sof;
            r_out_eof   <= w_out_eof;
            r_frame_cnt <= w_frame_cnt;
            r_err_ovf   <= w_err_ovf;
            r_err_sop   <= w_err_sop;
            r_err_len   <= w_err_len;
            r_ready     <= w_ready;
        end
    end

    assign bus.st_ready_out = r_ready;
    assign bus.line_data    = r_out_data;
    assign bus.line_valid   = r_out_valid;
    assign bus.line_sof     = r_out_sof;
    assign bus.line_eof     = r_out_eof;
    assign frame_cnt        = r_frame_cnt;
    assign err_overflow     = r_err_ovf;
    assign err_sop          = r_err_sop;
    assign err_len          = r_err_len;
endmodule
`default_nettype wire

// File: tb/tb_trb_line_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trb_line_packer
//  Brief    : Randomized and directed bench for trb_line_packer against a
//             frame-level reference model.
//  Revision : 1.0
// ============================================================================
module tb_trb_line_packer;
    localparam int FB = 128;
    localparam int LB = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] frame_cnt;
    logic        err_overflow, err_sop, err_len;

    trb_line_packer_if #(.LINE_BYTES(LB)) bus ();

    trb_line_packer #(.FRAME_BYTES(FB), .LINE_BYTES(LB), .SKID(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .frame_cnt    (frame_cnt),
        .err_overflow (err_overflow),
        .err_sop      (err_sop),
        .err_len      (err_len)
    );

    always #5 clk = ~clk;

    typedef struct { logic [8*LB-1:0] data; logic sof; logic eof; } line_t;
    typedef struct { logic [7:0] b; bit sop; bit eop; bit drop; } sbyte_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] cur[$];
    line_t      exp_q[$];
    sbyte_t     stim_q[$];
    int exp_sop = 0, exp_len = 0, exp_ovf = 0, exp_frames = 0;
    int got_sop = 0, got_len = 0, got_ovf = 0;
    int ready_fall_at;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: frame bytes collected in order, chopped into lines on
    // line-size boundaries and at frame end.
    task automatic model_byte(input logic [7:0] b, input bit sop, input bit eop);
        int    n, base;
        bit    fin;
        line_t ln;
        if (sop && cur.size() != 0) begin
            exp_sop++;
            cur.delete();
        end else if (!sop && cur.size() == 0) begin
            exp_sop++;
        end
        cur.push_back(b);
        n   = cur.size();
        fin = eop || (n == FB);
        if (fin && !(eop && n == FB)) exp_len++;
        if ((n % LB) == 0 || fin) begin
            base    = ((n - 1) / LB) * LB;
            ln.data = '0;
            for (int i = base; i < n; i++) ln.data[(i-base)*8 +: 8] = cur[i];
            ln.sof  = (base == 0);
            ln.eof  = fin;
            exp_q.push_back(ln);
            if (fin) exp_frames++;
        end
        if (fin) cur.delete();
    endtask

    task automatic add_frame(input int len, input bit sop_first, input bit eop_last, input bit rnd);
        sbyte_t s;
        for (int i = 0; i < len; i++) begin
            s.b    = rnd ? 8'($urandom) : 8'(i);
            s.sop  = sop_first && (i == 0);
            s.eop  = eop_last && (i == len - 1);
            s.drop = 1'b0;
            stim_q.push_back(s);
        end
    endtask

    // lat: cycles of ready-to-valid latency emulated upstream
    task automatic stream(input int lat, input bit honor, input int gap_pct, input int rdy_pct);
        logic [3:0] hist;
        int         sent = 0;
        int         cyc  = 0;
        bit         seen_hi = 1'b0;
        bit         ok;
        sbyte_t     s;
        hist = {4{bus.st_ready_out}};
        ready_fall_at = -1;
        while (stim_q.size() != 0) begin
            hist = {hist[2:0], bus.st_ready_out};
            if (bus.st_ready_out) seen_hi = 1'b1;
            else if (seen_hi && ready_fall_at < 0) ready_fall_at = sent;
            if (rdy_pct >= 0) bus.line_ready = (int'($urandom_range(99)) < rdy_pct);
            ok = !honor || hist[lat[1:0]];
            if (ok && int'($urandom_range(99)) >= gap_pct) begin
                s = stim_q.pop_front();
                bus.st_valid_in = 1'b1;
                bus.st_data_in  = s.b;
                bus.st_sop_in   = s.sop;
                bus.st_eop_in   = s.eop;
                sent++;
                if (s.drop) exp_ovf++;
                else model_byte(s.b, s.sop, s.eop);
            end else begin
                bus.st_valid_in = 1'b0;
                bus.st_sop_in   = 1'b0;
                bus.st_eop_in   = 1'b0;
            end
            tick();
            cyc++;
            if (cyc > 40000) begin
                check("stream_timeout", 512'(1), 512'(0));
                stim_q.delete();
            end
        end
        bus.st_valid_in = 1'b0;
        bus.st_sop_in   = 1'b0;
        bus.st_eop_in   = 1'b0;
    endtask

    task automatic drain(input string tag);
        int cyc = 0;
        bus.line_ready = 1'b1;
        while (exp_q.size() != 0 && cyc < 2000) begin
            tick();
            cyc++;
        end
        if (exp_q.size() != 0) check({tag, "_drain_timeout"}, 512'(exp_q.size()), 512'(0));
        repeat (3) tick();
        check({tag, "_idle_valid"}, 512'(bus.line_valid), 512'(0));
        check({tag, "_frame_cnt"}, 512'(frame_cnt), 512'(exp_frames[15:0]));
        check({tag, "_err_sop"}, 512'(got_sop), 512'(exp_sop));
        check({tag, "_err_len"}, 512'(got_len), 512'(exp_len));
        check({tag, "_err_ovf"}, 512'(got_ovf), 512'(exp_ovf));
    endtask

    always @(negedge clk) begin : mon
        line_t ln;
        if (!rst) begin
            if (err_sop)      got_sop++;
            if (err_len)      got_len++;
            if (err_overflow) got_ovf++;
            if (bus.line_valid && bus.line_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_line", 512'(1), 512'(0));
                end else begin
                    ln = exp_q.pop_front();
                    check("line_data", bus.line_data, ln.data);
                    check("line_sof", 512'(bus.line_sof), 512'(ln.sof));
                    check("line_eof", 512'(bus.line_eof), 512'(ln.eof));
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 512'(bus.line_valid), 512'(0));
        check({tag, "_sof"}, 512'(bus.line_sof), 512'(0));
        check({tag, "_eof"}, 512'(bus.line_eof), 512'(0));
        check({tag, "_data"}, bus.line_data, 512'(0));
        check({tag, "_frame_cnt"}, 512'(frame_cnt), 512'(0));
        check({tag, "_errs"}, 512'({err_overflow, err_sop, err_len}), 512'(0));
        check({tag, "_ready"}, 512'(bus.st_ready_out), 512'(0));
    endtask

    initial begin
        sbyte_t s;
        int     kind;
        rst             = 1'b1;
        bus.st_data_in  = '0;
        bus.st_valid_in = 1'b0;
        bus.st_sop_in   = 1'b0;
        bus.st_eop_in   = 1'b0;
        bus.line_ready  = 1'b0;
        repeat (3) tick();
        check_reset_state("rst0");
        rst = 1'b0;
        tick();
        check("rst0_ready_rise", 512'(bus.st_ready_out), 512'(1));

        // Two back-to-back counting frames
        bus.line_ready = 1'b1;
        add_frame(FB, 1, 1, 0);
        add_frame(FB, 1, 1, 0);
        stream(0, 1, 0, -1);
        drain("t1");

        // Stalled consumer, upstream with 3-cycle ready latency
        bus.line_ready = 1'b0;
        add_frame(FB, 1, 1, 0);
        stream(3, 1, 0, -1);
        check("t2_ready_fall_bytes", 512'(ready_fall_at), 512'(LB + 61));
        check("t2_ready_low", 512'(bus.st_ready_out), 512'(0));
        check("t2_line_held", 512'(bus.line_valid), 512'(1));
        drain("t2");

        // Ready ignored: two excess bytes must be dropped
        bus.line_ready = 1'b0;
        add_frame(FB, 1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            s.b = 8'hA5; s.sop = 1'b0; s.eop = 1'b0; s.drop = 1'b1;
            stim_q.push_back(s);
        end
        stream(0, 0, 0, -1);
        drain("t3");

        // Early eop after 100 bytes
        add_frame(100, 1, 1, 0);
        stream(0, 1, 0, -1);
        drain("t4");

        // sop at byte 70 restarts the frame
        add_frame(70, 1, 0, 0);
        add_frame(FB, 1, 1, 1);
        stream(0, 1, 0, -1);
        drain("t5");

        // Randomized mix of clean and malformed frames
        for (int f = 0; f < 40; f++) begin
            kind = (f == 39) ? 0 : int'($urandom_range(9));
            case (kind)
                5:       add_frame(1 + int'($urandom_range(126)), 1, 1, 1);
                6:       add_frame(FB, 1, 0, 1);
                7:       add_frame(1 + int'($urandom_range(126)), 1, 0, 1);
                8:       add_frame(FB, 0, 1, 1);
                default: add_frame(FB, 1, 1, 1);
            endcase
        end
        stream(0, 1, 20, 70);
        drain("rnd");

        // Reset mid-line discards buffered bytes
        bus.line_ready = 1'b1;
        add_frame(30, 1, 0, 1);
        stream(0, 1, 0, -1);
        rst = 1'b1;
        tick();
        check_reset_state("t6");
        cur.delete();
        exp_q.delete();
        exp_frames = 0;
        exp_sop = 0; exp_len = 0; exp_ovf = 0;
        got_sop = 0; got_len = 0; got_ovf = 0;
        rst = 1'b0;
        tick();
        check("t6_ready_rise", 512'(bus.st_ready_out), 512'(1));
        add_frame(FB, 1, 1, 1);
        stream(0, 1, 0, -1);
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
